picorv_ctrl: RTL and testbench

// - PicoRV control core: fetches instructions from a 32-bit memory port, announces each one on a decode port.
// - Dispatches it to a PCPI execution unit with register operands; owns the register file, PC and rd scoreboard.
// - Accepts async writebacks from long-latency units. Sits between instruction memory and the PCPI units.

---
 rtl/picorv_pkg.sv | 17 +
 rtl/picorv_regfile.sv | 54 +++++
 rtl/picorv_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_picorv_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/picorv_pkg.sv
// Shared definitions for the PicoRV control core: instruction field positions,
// halfword/word sizes and the compressed-instruction length test.
package picorv_pkg;
  localparam int HALF_W     = 16;
  localparam int WORD_W     = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int RD_LSB     = 7;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int RS3_LSB    = 27;

  // Low two bits of the first halfword equal to 2'b11 mark a 32-bit instruction.
  function automatic logic is_long(input logic [HALF_W-1:0] prefix);
    return prefix[1:0] == 2'b11;
  endfunction
endpackage

// File: rtl/picorv_regfile.sv
// 32-entry register file with combinational read ports, one write port,
// hardwired x0 and a per-register pending (async writeback) scoreboard.
module picorv_regfile
  import picorv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RPORTS = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [4:0]          wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                set_en,
  input  logic [4:0]          set_addr,
  input  logic                clr_en,
  input  logic [4:0]          clr_addr,
  input  logic [4:0]          rs1_addr,
  input  logic [4:0]          rs2_addr,
  input  logic [4:0]          rs3_addr,
  output logic [XLEN-1:0]     rs1_data,
  output logic [XLEN-1:0]     rs2_data,
  output logic [XLEN-1:0]     rs3_data,
  output logic [NUM_REGS-1:0] pending
);

  logic [XLEN-1:0] regs [0:NUM_REGS-1];

  always_ff @(posedge clock) begin
    if (wr_en && wr_addr != 5'd0) regs[wr_addr] <= wr_data;
  end

  // Clear before set so a register re-marked in the same cycle stays pending.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
    end else begin
      if (clr_en) pending[clr_addr] <= 1'b0;
      if (set_en && set_addr != 5'd0) pending[set_addr] <= 1'b1;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

  generate
    if (RPORTS >= 3) begin : g_rs3
      assign rs3_data = (rs3_addr == 5'd0) ? '0 : regs[rs3_addr];
    end else begin : g_no_rs3
      assign rs3_data = '0;
    end
  endgenerate

endmodule

// File: rtl/picorv_ctrl.sv
// PicoRV control core: word fetch into a 3-halfword buffer, decode/PCPI
// dispatch stage, PC tracking, branch redirect and async writeback arbitration.
module picorv_ctrl
  import picorv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ILEN   = 32,
  parameter int IALIGN = 16,
  parameter int RPORTS = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] rvec,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  input  logic [31:0]     mem_rdata,
  output logic            decode_valid,
  output logic [ILEN-1:0] decode_insn,
  output logic [15:0]     decode_prefix,
  output logic            pcpi_valid,
  output logic [ILEN-1:0] pcpi_insn,
  output logic [15:0]     pcpi_prefix,
  output logic [XLEN-1:0] pcpi_pc,
  output logic            pcpi_rs1_valid,
  output logic [XLEN-1:0] pcpi_rs1_data,
  output logic            pcpi_rs2_valid,
  output logic [XLEN-1:0] pcpi_rs2_data,
  output logic            pcpi_rs3_valid,
  output logic [XLEN-1:0] pcpi_rs3_data,
  input  logic            pcpi_ready,
  output logic            pcpi_wb_valid,
  input  logic            pcpi_wb_write,
  input  logic            pcpi_wb_async,
  input  logic [XLEN-1:0] pcpi_wb_data,
  input  logic            pcpi_br_enable,
  input  logic [XLEN-1:0] pcpi_br_nextpc,
  input  logic            awb_valid,
  output logic            awb_ready,
  input  logic [4:0]      awb_addr,
  input  logic [XLEN-1:0] awb_data
);

  logic [XLEN-1:0] fetch_pc, fetch_pc_n, dec_pc;
  logic            discard;
  logic [47:0]     buf_vec, buf_vec_n, rem_vec;
  logic [1:0]      buf_cnt, buf_cnt_n, rem_cnt, pop_n, push_n;
  logic [31:0]     push_word;
  logic [15:0]     hw0, hw1;
  logic            head_long, head_full, retire, branch, mem_done, accept, issue;

  logic            vld_p1;
  logic [ILEN-1:0] insn_p1;
  logic [15:0]     prefix_p1;
  logic [XLEN-1:0] pc_p1;

  logic [4:0]          rd, rs1, rs2, rs3;
  logic [NUM_REGS-1:0] pending;
  logic                pcpi_wr, awb_fire;

  assign hw0       = buf_vec[15:0];
  assign hw1       = buf_vec[31:16];
  assign head_long = (IALIGN == 32) || is_long(hw0);
  assign head_full = (buf_cnt != 2'd0) && (!head_long || buf_cnt >= 2'd2);

  assign retire   = vld_p1 && pcpi_ready;
  assign branch   = retire && pcpi_br_enable;
  assign mem_done = mem_valid && mem_ready;
  assign accept   = mem_done && !discard && !branch;

  assign decode_valid  = head_full && (!vld_p1 || (pcpi_ready && !pcpi_br_enable));
  assign decode_insn   = ILEN'(head_long ? {hw1, hw0} : {16'h0000, hw0});
  assign decode_prefix = hw0;

  // Buffer update: drop the decoded halfwords, then append the fetched ones.
  always_comb begin
    pop_n = decode_valid ? (head_long ? 2'd2 : 2'd1) : 2'd0;
    case (pop_n)
      2'd1:    rem_vec = {16'h0000, buf_vec[47:16]};
      2'd2:    rem_vec = {32'h0000_0000, buf_vec[47:32]};
      default: rem_vec = buf_vec;
    endcase
    rem_cnt   = buf_cnt - pop_n;
    push_n    = 2'd0;
    push_word = 32'h0000_0000;
    if (accept) begin
      if (fetch_pc[1]) begin
        push_n    = 2'd1;
        push_word = {16'h0000, mem_rdata[31:16]};
      end else begin
        push_n    = 2'd2;
        push_word = mem_rdata;
      end
    end
    case (rem_cnt)
      2'd0:    buf_vec_n = {16'h0000, push_word};
      2'd1:    buf_vec_n = {push_word, rem_vec[15:0]};
      2'd2:    buf_vec_n = {push_word[15:0], rem_vec[31:0]};
      default: buf_vec_n = rem_vec;
    endcase
    buf_cnt_n = branch ? 2'd0 : rem_cnt + push_n;
  end

  always_comb begin
    fetch_pc_n = fetch_pc;
    if (branch)      fetch_pc_n = pcpi_br_nextpc;
    else if (accept) fetch_pc_n = {fetch_pc[XLEN-1:2], 2'b00} + XLEN'(4);
    issue = (!mem_valid || mem_ready) && (buf_cnt_n <= 2'd1);
  end

  // Fetch / buffer / decode-PC control state
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_valid <= 1'b0;
      discard   <= 1'b0;
      buf_cnt   <= 2'd0;
      fetch_pc  <= rvec;
      dec_pc    <= rvec;
      vld_p1    <= 1'b0;
    end else begin
      mem_valid <= (mem_valid && !mem_ready) || issue;
      if (mem_done)                discard <= 1'b0;
      else if (branch && mem_valid) discard <= 1'b1;
      buf_cnt  <= buf_cnt_n;
      fetch_pc <= fetch_pc_n;
      if (branch)            dec_pc <= pcpi_br_nextpc;
      else if (decode_valid) dec_pc <= dec_pc + (head_long ? XLEN'(4) : XLEN'(2));
      if (decode_valid) vld_p1 <= 1'b1;
      else if (retire)  vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    buf_vec <= buf_vec_n;
    if (issue) mem_addr <= {fetch_pc_n[XLEN-1:2], 2'b00};
  end

  // PCPI stage (p1): loaded from decode, held while the unit is busy
  always_ff @(posedge clock) begin
    if (decode_valid) begin
      insn_p1   <= decode_insn;
      prefix_p1 <= hw0;
      pc_p1     <= dec_pc;
    end
  end

  assign pcpi_valid  = vld_p1;
  assign pcpi_insn   = insn_p1;
  assign pcpi_prefix = prefix_p1;
  assign pcpi_pc     = pc_p1;

  assign rd  = insn_p1[RD_LSB  +: REG_ADDR_W];
  assign rs1 = insn_p1[RS1_LSB +: REG_ADDR_W];
  assign rs2 = insn_p1[RS2_LSB +: REG_ADDR_W];
  assign rs3 = insn_p1[RS3_LSB +: REG_ADDR_W];

  // The unit's writeback owns the single write port; awb waits for a free cycle.
  assign pcpi_wr   = retire && pcpi_wb_write;
  assign awb_ready = !pcpi_wr;
  assign awb_fire  = awb_valid && awb_ready;

  picorv_regfile #(
    .XLEN   (XLEN),
    .RPORTS (RPORTS)
  ) u_regfile (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (pcpi_wr || awb_fire),
    .wr_addr  (pcpi_wr ? rd : awb_addr),
    .wr_data  (pcpi_wr ? pcpi_wb_data : awb_data),
    .set_en   (retire && pcpi_wb_async),
    .set_addr (rd),
    .clr_en   (awb_fire),
    .clr_addr (awb_addr),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs3_addr (rs3),
    .rs1_data (pcpi_rs1_data),
    .rs2_data (pcpi_rs2_data),
    .rs3_data (pcpi_rs3_data),
    .pending  (pending)
  );

  assign pcpi_rs1_valid = !pending[rs1];
  assign pcpi_rs2_valid = !pending[rs2];
  assign pcpi_rs3_valid = (RPORTS >= 3) ? !pending[rs3] : 1'b0;
  assign pcpi_wb_valid  = vld_p1 && !pending[rd];

endmodule

// File: tb/tb_picorv_ctrl.sv
// Directed bench for picorv_ctrl: zero-wait instruction memory model and a
// hand-driven PCPI unit, with hand-computed expectations.
module tb_picorv_ctrl;
  logic        clock, reset;
  logic [31:0] rvec;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_rdata;
  logic        decode_valid;
  logic [31:0] decode_insn;
  logic [15:0] decode_prefix;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [15:0] pcpi_prefix;
  logic [31:0] pcpi_pc;
  logic        pcpi_rs1_valid, pcpi_rs2_valid, pcpi_rs3_valid;
  logic [31:0] pcpi_rs1_data, pcpi_rs2_data, pcpi_rs3_data;
  logic        pcpi_ready, pcpi_wb_valid, pcpi_wb_write, pcpi_wb_async;
  logic [31:0] pcpi_wb_data;
  logic        pcpi_br_enable;
  logic [31:0] pcpi_br_nextpc;
  logic        awb_valid, awb_ready;
  logic [4:0]  awb_addr;
  logic [31:0] awb_data;

  logic [31:0] mem [0:255];
  int          total, bad;
  logic        log_en;
  logic [31:0] addr_q[$];

  picorv_ctrl dut (
    .clock(clock), .reset(reset), .rvec(rvec),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .decode_valid(decode_valid), .decode_insn(decode_insn), .decode_prefix(decode_prefix),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_prefix(pcpi_prefix), .pcpi_pc(pcpi_pc),
    .pcpi_rs1_valid(pcpi_rs1_valid), .pcpi_rs1_data(pcpi_rs1_data),
    .pcpi_rs2_valid(pcpi_rs2_valid), .pcpi_rs2_data(pcpi_rs2_data),
    .pcpi_rs3_valid(pcpi_rs3_valid), .pcpi_rs3_data(pcpi_rs3_data),
    .pcpi_ready(pcpi_ready), .pcpi_wb_valid(pcpi_wb_valid), .pcpi_wb_write(pcpi_wb_write),
    .pcpi_wb_async(pcpi_wb_async), .pcpi_wb_data(pcpi_wb_data),
    .pcpi_br_enable(pcpi_br_enable), .pcpi_br_nextpc(pcpi_br_nextpc),
    .awb_valid(awb_valid), .awb_ready(awb_ready), .awb_addr(awb_addr), .awb_data(awb_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @* begin
    mem_ready = mem_valid;
    mem_rdata = mem[mem_addr[9:2]];
  end

  always @(negedge clock) begin
    if (log_en && mem_valid && mem_ready) addr_q.push_back(mem_addr);
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'h00, rs2, rs1, 3'h0, rd, 7'h33};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    pcpi_ready = 0; pcpi_wb_write = 0; pcpi_wb_async = 0; pcpi_wb_data = 0;
    pcpi_br_enable = 0; pcpi_br_nextpc = 0;
    awb_valid = 0; awb_addr = 0; awb_data = 0;
  endtask

  task automatic wait_pcpi(input string tag);
    int n;
    n = 0;
    while (!pcpi_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    check(tag, pcpi_valid, 1'b1);
  endtask

  task automatic complete(input logic wr, input logic as, input logic [31:0] data,
                          input logic br, input logic [31:0] tgt);
    pcpi_ready = 1; pcpi_wb_write = wr; pcpi_wb_async = as; pcpi_wb_data = data;
    pcpi_br_enable = br; pcpi_br_nextpc = tgt;
    #1;
    if (br) check("br_no_decode", decode_valid, 1'b0);
    @(negedge clock);
    idle();
  endtask

  logic [31:0] i0, i1, i2, i3, i4, i5, i6;

  initial begin
    total = 0; bad = 0; log_en = 0;
    idle();
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    i0 = mk(5'd5, 5'd0, 5'd0);
    i1 = mk(5'd7, 5'd5, 5'd0);
    i2 = mk(5'd7, 5'd7, 5'd5);
    i3 = mk(5'd0, 5'd7, 5'd0);
    i4 = mk(5'd1, 5'd1, 5'd1);
    i5 = mk(5'd10, 5'd5, 5'd7);
    mem[8'h40] = i0; mem[8'h41] = i1; mem[8'h42] = i2; mem[8'h43] = i3; mem[8'h44] = i4;
    mem[8'h80] = {i5[15:0], 16'h0001};
    mem[8'h81] = {16'h0000, i5[31:16]};
    rvec = 32'h100;
    reset = 1;
    repeat (3) @(negedge clock);
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_decode_valid", decode_valid, 1'b0);
    check("rst_pcpi_valid", pcpi_valid, 1'b0);

    // Sequential 32-bit fetch, writeback, async hazard, stall
    log_en = 1;
    reset = 0;
    @(negedge clock);
    wait_pcpi("a0_dispatch");
    check("a0_pc", pcpi_pc, 32'h100);
    check("a0_insn", pcpi_insn, i0);
    check("a0_wb_valid", pcpi_wb_valid, 1'b1);
    complete(1, 0, 32'hDEAD, 0, 0);

    wait_pcpi("a1_dispatch");
    check("a1_pc", pcpi_pc, 32'h104);
    check("a1_rs1_valid", pcpi_rs1_valid, 1'b1);
    check("a1_rs1_data", pcpi_rs1_data, 32'hDEAD);
    complete(0, 1, 0, 0, 0);

    wait_pcpi("a2_dispatch");
    check("a2_pc", pcpi_pc, 32'h108);
    check("a2_rs1_valid", pcpi_rs1_valid, 1'b0);
    check("a2_wb_valid", pcpi_wb_valid, 1'b0);
    check("a2_rs2_data", pcpi_rs2_data, 32'hDEAD);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("hold_pc", pcpi_pc, 32'h108);
      check("hold_insn", pcpi_insn, i2);
      check("hold_prefix", pcpi_prefix, i2[15:0]);
      check("hold_rs2", pcpi_rs2_data, 32'hDEAD);
      check("hold_rs1_valid", pcpi_rs1_valid, 1'b0);
      check("hold_no_decode", decode_valid, 1'b0);
    end
    awb_valid = 1; awb_addr = 5'd7; awb_data = 32'h1234;
    #1;
    check("awb_ready_free", awb_ready, 1'b1);
    @(negedge clock);
    awb_valid = 0;
    check("awb_rs1_valid", pcpi_rs1_valid, 1'b1);
    check("awb_rs1_data", pcpi_rs1_data, 32'h1234);
    check("awb_wb_valid", pcpi_wb_valid, 1'b1);
    pcpi_ready = 1; pcpi_wb_write = 1; pcpi_wb_data = 32'h5555;
    awb_valid = 1; awb_addr = 5'd9; awb_data = 32'h9999;
    #1;
    check("awb_collide", awb_ready, 1'b0);
    check("ready_decode", decode_valid, 1'b1);
    @(negedge clock);
    idle();

    wait_pcpi("a3_dispatch");
    check("a3_pc", pcpi_pc, 32'h10C);
    check("a3_insn", pcpi_insn, i3);
    check("a3_rs1_data", pcpi_rs1_data, 32'h5555);
    complete(0, 0, 0, 1, 32'h202);
    check("br_bubble", pcpi_valid, 1'b0);

    wait_pcpi("a5_dispatch");
    check("a5_pc", pcpi_pc, 32'h202);
    check("a5_prefix", pcpi_prefix, i5[15:0]);
    check("a5_insn", pcpi_insn, i5);
    check("a5_rs1_data", pcpi_rs1_data, 32'hDEAD);
    check("a5_rs2_data", pcpi_rs2_data, 32'h5555);
    log_en = 0;
    check("addr_count", addr_q.size() >= 3, 1'b1);
    if (addr_q.size() >= 3) begin
      check("addr0", addr_q[0], 32'h100);
      check("addr1", addr_q[1], 32'h104);
      check("addr2", addr_q[2], 32'h108);
    end

    // Mid-operation reset, then RVC followed by a straddling 32-bit insn
    reset = 1;
    @(negedge clock);
    check("midrst_mem_valid", mem_valid, 1'b0);
    check("midrst_pcpi_valid", pcpi_valid, 1'b0);
    i6 = mk(5'd3, 5'd5, 5'd0);
    mem[8'h40] = {i6[15:0], 16'h0001};
    mem[8'h41] = {16'h0001, i6[31:16]};
    mem[8'h42] = 32'h0;
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    wait_pcpi("b0_dispatch");
    check("b0_pc", pcpi_pc, 32'h100);
    check("b0_insn", pcpi_insn, 32'h0000_0001);
    check("b0_prefix", pcpi_prefix, 16'h0001);
    complete(0, 0, 0, 0, 0);
    wait_pcpi("b1_dispatch");
    check("b1_pc", pcpi_pc, 32'h102);
    check("b1_insn", pcpi_insn, i6);
    check("b1_prefix", pcpi_prefix, i6[15:0]);
    complete(0, 0, 0, 0, 0);
    wait_pcpi("b2_dispatch");
    check("b2_pc", pcpi_pc, 32'h106);
    check("b2_insn", pcpi_insn, 32'h0000_0001);
    complete(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
